// File: rtl/touch_gesture_led_ctrl.sv
// Touch-key gesture controller: synchronise/debounce the key, classify taps and
// long presses, and drive the LED bank pattern (static, blink, marquee).
module touch_gesture_led_ctrl #(
  parameter int DEB_MAX   = 500_000,
  parameter int LONG_MAX  = 50_000_000,
  parameter int GAP_MAX   = 15_000_000,
  parameter int BLINK_MAX = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       led_en,
  output logic       single_evt,
  output logic       double_evt,
  output logic       long_evt,
  output logic [2:0] dbg_state
);

  localparam int T_MAX  = (LONG_MAX > GAP_MAX) ? LONG_MAX : GAP_MAX;
  localparam int DEB_W  = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
  localparam int TCNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PCNT_W = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_MAX - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
  localparam logic [TCNT_W-1:0] LONG_LAST  = TCNT_W'(LONG_MAX - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(GAP_MAX - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);
  localparam logic [PCNT_W-1:0] BLINK_LAST = PCNT_W'(BLINK_MAX - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               key_meta, key_s, key_db, key_db_q;
  logic               key_rise, key_fall;
  logic [DEB_W-1:0]   deb_cnt;
  logic [TCNT_W-1:0]  tcnt;
  logic [PCNT_W-1:0]  pcnt;
  logic               blink_ph;
  logic [3:0]         marquee;
  logic               single_nxt, double_nxt, long_nxt;
  logic               led_en_nxt;
  logic [1:0]         mode_nxt, mode_adv;
  logic               pat_restart;

  assign dbg_state = state;

  // Two-flop synchroniser followed by a stability-count debouncer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      key_meta <= touch_key;
      key_s    <= key_meta;
      key_db_q <= key_db;
      if (key_s == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_db  <= key_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  assign key_rise = key_db & ~key_db_q;
  assign key_fall = ~key_db & key_db_q;

  always_comb begin
    state_nxt  = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (key_rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (key_fall) begin
          state_nxt = WAIT2;
        end else if (tcnt == LONG_LAST && key_db) begin
          long_nxt  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (key_fall) state_nxt = IDLE;
      end
      WAIT2: begin
        // A second press beats a simultaneous gap timeout.
        if (key_rise) begin
          state_nxt = PRESS2;
        end else if (tcnt == GAP_LAST) begin
          single_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      PRESS2: begin
        if (key_fall) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
    end else begin
      state      <= state_nxt;
      single_evt <= single_nxt;
      double_evt <= double_nxt;
      long_evt   <= long_nxt;
      if (state_nxt != state) begin
        tcnt <= '0;
      end else if (state == PRESS1 || state == WAIT2) begin
        tcnt <= tcnt + TCNT_ONE;
      end else begin
        tcnt <= '0;
      end
    end
  end

  // Gesture actions land on the same edge that raises the event pulse.
  always_comb begin
    case (mode)
      2'd0:    mode_adv = 2'd1;
      2'd1:    mode_adv = 2'd2;
      default: mode_adv = 2'd0;
    endcase
    led_en_nxt = led_en;
    mode_nxt   = mode;
    if (long_nxt) begin
      led_en_nxt = 1'b0;
      mode_nxt   = 2'd0;
    end else if (double_nxt) begin
      led_en_nxt = 1'b1;
      mode_nxt   = mode_adv;
    end else if (single_nxt) begin
      led_en_nxt = ~led_en;
    end
    pat_restart = (mode_nxt != mode) || (led_en_nxt && !led_en);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_en   <= 1'b0;
      mode     <= 2'd0;
      pcnt     <= '0;
      blink_ph <= 1'b0;
      marquee  <= 4'b0001;
    end else begin
      led_en <= led_en_nxt;
      mode   <= mode_nxt;
      if (pat_restart) begin
        pcnt     <= '0;
        blink_ph <= 1'b1;
        marquee  <= 4'b0001;
      end else if (pcnt == BLINK_LAST) begin
        pcnt     <= '0;
        blink_ph <= ~blink_ph;
        marquee  <= {marquee[2:0], marquee[3]};
      end else begin
        pcnt <= pcnt + PCNT_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= 4'b0000;
    end else if (!led_en) begin
      led <= 4'b0000;
    end else begin
      case (mode)
        2'd0:    led <= 4'b1111;
        2'd1:    led <= {4{blink_ph}};
        2'd2:    led <= marquee;
        default: led <= 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_gesture_led_ctrl.sv
// Directed bench for touch_gesture_led_ctrl with shrunk timing parameters and
// hand-derived latencies counted in clock edges from the touch_key change.
module tb_touch_gesture_led_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       touch_key;
  logic [3:0] led;
  logic [1:0] mode;
  logic       led_en;
  logic       single_evt, double_evt, long_evt;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int n_single = 0;
  int n_double = 0;
  int n_long   = 0;
  int lat;

  touch_gesture_led_ctrl #(
    .DEB_MAX(4), .LONG_MAX(100), .GAP_MAX(40), .BLINK_MAX(10)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .touch_key(touch_key),
    .led(led), .mode(mode), .led_en(led_en),
    .single_evt(single_evt), .double_evt(double_evt), .long_evt(long_evt),
    .dbg_state(dbg_state)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  always @(negedge sys_clk) begin
    if (single_evt) n_single++;
    if (double_evt) n_double++;
    if (long_evt)   n_long++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_for(input int n);
    touch_key = 1'b1;
    repeat (n) @(negedge sys_clk);
    touch_key = 1'b0;
  endtask

  // which: 0 single, 1 double, 2 long. Latency in edges, -1 on timeout.
  task automatic wait_evt(input int which, input int bound, output int l);
    l = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge sys_clk);
      if ((which == 0 && single_evt) || (which == 1 && double_evt) ||
          (which == 2 && long_evt)) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic double_tap();
    press_for(20);
    repeat (15) @(negedge sys_clk);
    press_for(20);
  endtask

  // Called on the sample right after the double_evt pulse.
  task automatic check_pattern(input int m);
    logic [3:0] exp_led;
    for (int j = 1; j <= 40; j++) begin
      @(negedge sys_clk);
      if (m == 0)      exp_led = 4'b1111;
      else if (m == 1) exp_led = ((((j - 1) / 10) % 2) == 0) ? 4'b1111 : 4'b0000;
      else             exp_led = 4'(1 << (((j - 1) / 10) % 4));
      check_eq($sformatf("pattern_m%0d_j%0d", m, j), 32'(led), 32'(exp_led));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_led"},    32'(led), 0);
    check_eq({tag, "_mode"},   32'(mode), 0);
    check_eq({tag, "_led_en"}, 32'(led_en), 0);
    check_eq({tag, "_evts"},   32'({single_evt, double_evt, long_evt}), 0);
    check_eq({tag, "_state"},  32'(dbg_state), 0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    touch_key = 1'b0;

    // Reset held with the key toggling.
    repeat (10) begin
      #20 touch_key = ~touch_key;
    end
    touch_key = 1'b0;
    check_reset_outputs("in_reset");
    check_eq("in_reset_no_pulses", 32'(n_single + n_double + n_long), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_reset_outputs("after_reset");

    // Single tap on, single tap off.
    press_for(30);
    wait_evt(0, 100, lat);
    check_eq("tap1_latency", 32'(lat), 47);
    check_eq("tap1_led_en", 32'(led_en), 1);
    @(negedge sys_clk);
    check_eq("tap1_led", 32'(led), 32'hF);
    press_for(30);
    wait_evt(0, 100, lat);
    check_eq("tap2_latency", 32'(lat), 47);
    check_eq("tap2_led_en", 32'(led_en), 0);
    @(negedge sys_clk);
    check_eq("tap2_led", 32'(led), 0);
    repeat (20) @(negedge sys_clk);
    check_eq("taps_single_cnt", 32'(n_single), 2);
    check_eq("taps_double_cnt", 32'(n_double), 0);

    // Double taps cycle the pattern mode.
    double_tap();
    wait_evt(1, 100, lat);
    check_eq("dbl1_latency", 32'(lat), 7);
    check_eq("dbl1_mode", 32'(mode), 1);
    check_eq("dbl1_led_en", 32'(led_en), 1);
    check_pattern(1);
    check_eq("dbl1_double_cnt", 32'(n_double), 1);
    check_eq("dbl1_single_cnt", 32'(n_single), 2);

    double_tap();
    wait_evt(1, 100, lat);
    check_eq("dbl2_mode", 32'(mode), 2);
    check_pattern(2);

    double_tap();
    wait_evt(1, 100, lat);
    check_eq("dbl3_mode", 32'(mode), 0);
    check_pattern(0);

    double_tap();
    wait_evt(1, 100, lat);
    check_eq("dbl4_mode", 32'(mode), 1);
    double_tap();
    wait_evt(1, 100, lat);
    check_eq("dbl5_mode", 32'(mode), 2);
    repeat (20) @(negedge sys_clk);
    check_eq("dbl_double_cnt", 32'(n_double), 5);
    check_eq("dbl_single_cnt", 32'(n_single), 2);

    // Long press from marquee mode.
    touch_key = 1'b1;
    wait_evt(2, 200, lat);
    check_eq("long_latency", 32'(lat), 107);
    check_eq("long_mode", 32'(mode), 0);
    check_eq("long_led_en", 32'(led_en), 0);
    @(negedge sys_clk);
    check_eq("long_led", 32'(led), 0);
    repeat (190) @(negedge sys_clk);
    touch_key = 1'b0;
    repeat (100) @(negedge sys_clk);
    check_eq("long_cnt", 32'(n_long), 1);
    check_eq("long_single_cnt", 32'(n_single), 2);
    check_eq("long_double_cnt", 32'(n_double), 5);
    check_eq("long_state_idle", 32'(dbg_state), 0);

    // Short glitches never pass the debouncer.
    repeat (20) begin
      touch_key = 1'b1;
      repeat (3) @(negedge sys_clk);
      touch_key = 1'b0;
      repeat (7) @(negedge sys_clk);
      check_eq("glitch_state", 32'(dbg_state), 0);
    end
    check_eq("glitch_evts", 32'(n_single + n_double + n_long), 8);
    check_eq("glitch_led", 32'(led), 0);

    // Reset in HOLD with the key kept down across release.
    touch_key = 1'b1;
    wait_evt(2, 200, lat);
    repeat (10) @(negedge sys_clk);
    check_eq("hold_state", 32'(dbg_state), 2);
    #5 sys_rst_n = 1'b0;
    #1 check_reset_outputs("rst_hold");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_evt(2, 200, lat);
    check_eq("held_release_long_latency", 32'(lat), 107);
    touch_key = 1'b0;
    repeat (20) @(negedge sys_clk);
    check_eq("hold_long_cnt", 32'(n_long), 3);

    // Enable, then reset in WAIT2 while lit.
    press_for(30);
    wait_evt(0, 100, lat);
    check_eq("tap3_latency", 32'(lat), 47);
    @(negedge sys_clk);
    check_eq("tap3_led", 32'(led), 32'hF);
    press_for(30);
    repeat (20) @(negedge sys_clk);
    check_eq("wait2_state", 32'(dbg_state), 3);
    #5 sys_rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait2");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    check_eq("wait2_single_cnt", 32'(n_single), 3);
    check_eq("wait2_led_en", 32'(led_en), 0);
    check_eq("wait2_led", 32'(led), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
